// File: rtl/ex_div.sv
// -----------------------------------------------------------------------------
// ex_div -- iterative radix-2 restoring divider for DIV / DIVU
//
// Sits inside the execute stage and produces {remainder, quotient} for the
// HI/LO result path. One quotient bit is resolved per clock, so a division takes
// DATA_WIDTH iterations. stallreq holds the pipeline until the result is ready.
// Only one division is in flight at a time.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   div_start    division requested; EX holds it high until div_ready is seen
//   div_signed   1 = DIV (two's complement), 0 = DIVU
//   div_opdata1  dividend  (sampled only on the edge that leaves IDLE)
//   div_opdata2  divisor   (sampled only on the edge that leaves IDLE)
//   div_annul    pipeline flush; aborts any division, wins over div_start
//   div_result   {remainder (HI), quotient (LO)}, valid while div_ready=1
//   div_ready    result valid; held while div_start stays high
//   div_byzero   present only when DIV_BYZERO_FLAG_EN is defined: high while
//                div_ready=1 for a division whose divisor was zero
//   stallreq     div_start & ~div_ready (combinational)
//
// Build option
//   DIV_BYZERO_FLAG_EN  adds the div_byzero output. Without it a divide by
//                       zero simply returns 0 and cannot be told apart.
//
// Timing (edge 0 = the edge leaving IDLE)
//   normal  : restoring steps on edges 1..DATA_WIDTH, ready after edge DATA_WIDTH
//   by zero : ready after edge 1
// -----------------------------------------------------------------------------
module ex_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_start,
  input  logic                    div_signed,
  input  logic [DATA_WIDTH-1:0]   div_opdata1,
  input  logic [DATA_WIDTH-1:0]   div_opdata2,
  input  logic                    div_annul,
  output logic [2*DATA_WIDTH-1:0] div_result,
  output logic                    div_ready,
`ifdef DIV_BYZERO_FLAG_EN
  output logic                    div_byzero,
`endif
  output logic                    stallreq
);

  localparam int DW = DATA_WIDTH;
  // Counter must reach DW-1; one spare bit keeps the width sane for any DW.
  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BYZERO = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] counter;
  logic [DW-1:0] rem_reg;    // partial remainder
  logic [DW-1:0] quo_reg;    // starts as |dividend|, quotient bits shift in at the LSB
  logic [DW-1:0] dvs_reg;    // |divisor|
  logic          neg_quo;    // operand signs differ (signed mode only)
  logic          neg_rem;    // dividend negative (signed mode only)
`ifdef DIV_BYZERO_FLAG_EN
  logic          byz_reg;
`endif

  // ---------------------------------------------------------------------------
  // Operand magnitudes: negate negative operands only for DIV.
  // ---------------------------------------------------------------------------
  logic          op1_neg, op2_neg;
  logic [DW-1:0] op1_abs, op2_abs;

  always_comb begin
    op1_neg = div_signed & div_opdata1[DW-1];
    op2_neg = div_signed & div_opdata2[DW-1];
    op1_abs = op1_neg ? (~div_opdata1 + DW'(1)) : div_opdata1;
    op2_abs = op2_neg ? (~div_opdata2 + DW'(1)) : div_opdata2;
  end

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted remainder can be DW+1 bits wide, so the
  // trial subtraction is done at DW+1 bits and its MSB is the borrow.
  // ---------------------------------------------------------------------------
  logic [DW:0]   rem_shift;
  logic [DW:0]   trial;
  logic          no_borrow;
  logic [DW-1:0] step_rem;
  logic [DW-1:0] step_quo;

  always_comb begin
    rem_shift = {rem_reg, quo_reg[DW-1]};
    trial     = rem_shift - {1'b0, dvs_reg};
    no_borrow = ~trial[DW];
    step_rem  = no_borrow ? trial[DW-1:0] : rem_shift[DW-1:0];
    step_quo  = {quo_reg[DW-2:0], no_borrow};
  end

  // ---------------------------------------------------------------------------
  // Sign fix on the final step. The most-negative / -1 case falls out
  // naturally: magnitude quotient 2^(DW-1) negates back onto itself.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] fix_quo;
  logic [DW-1:0] fix_rem;

  always_comb begin
    fix_quo = neg_quo ? (~step_quo + DW'(1)) : step_quo;
    fix_rem = neg_rem ? (~step_rem + DW'(1)) : step_rem;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      counter    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      div_result <= '0;
      div_ready  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
      byz_reg    <= 1'b0;
`endif
    end else if (div_annul) begin
      // Flush takes priority over everything, including a fresh div_start.
      state      <= ST_IDLE;
      counter    <= '0;
      div_result <= '0;
      div_ready  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
      byz_reg    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          div_result <= '0;
          div_ready  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
          byz_reg    <= 1'b0;
`endif
          if (div_start) begin
            if (div_opdata2 == '0) begin
              state <= ST_BYZERO;
            end else begin
              state   <= ST_ON;
              counter <= '0;
              rem_reg <= '0;
              quo_reg <= op1_abs;
              dvs_reg <= op2_abs;
              neg_quo <= op1_neg ^ op2_neg;
              neg_rem <= op1_neg;
            end
          end
        end

        ST_BYZERO: begin
          state      <= ST_END;
          div_result <= '0;
          div_ready  <= 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
          byz_reg    <= 1'b1;
`endif
        end

        ST_ON: begin
          rem_reg <= step_rem;
          quo_reg <= step_quo;
          counter <= counter + CW'(1);
          if (counter == LAST_STEP) begin
            state      <= ST_END;
            div_result <= {fix_rem, fix_quo};
            div_ready  <= 1'b1;
          end
        end

        ST_END: begin
          // Result is held until EX drops its request; no restart before that.
          if (!div_start) begin
            state      <= ST_IDLE;
            div_result <= '0;
            div_ready  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
            byz_reg    <= 1'b0;
`endif
          end
        end

        default: begin
          state      <= ST_IDLE;
          counter    <= '0;
          div_result <= '0;
          div_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign stallreq = div_start & ~div_ready;

`ifdef DIV_BYZERO_FLAG_EN
  assign div_byzero = byz_reg & div_ready;
`endif

endmodule

// File: tb/tb_ex_div.sv
// -----------------------------------------------------------------------------
// tb_ex_div -- scoreboard bench for ex_div
//
// The driver issues directed divisions and pushes the hand-computed result,
// expected latency and divide-by-zero flag into a queue. A monitor pops one
// entry whenever div_ready rises and compares. Latency is counted in rising
// edges after the edge that leaves IDLE: 32 for a normal division, 1 for a
// zero divisor.
// -----------------------------------------------------------------------------
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq;
`ifdef DIV_BYZERO_FLAG_EN
  logic        div_byzero;
`endif

  ex_div #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_opdata1 (div_opdata1),
    .div_opdata2 (div_opdata2),
    .div_annul   (div_annul),
    .div_result  (div_result),
    .div_ready   (div_ready),
`ifdef DIV_BYZERO_FLAG_EN
    .div_byzero  (div_byzero),
`endif
    .stallreq    (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    logic        bz;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic ready_prev = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge of div_ready.
  always @(negedge clk) begin
    if (div_ready && !ready_prev) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=%h expected=no_result", div_result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", div_result, mon_e.res);
        chk("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
`ifdef DIV_BYZERO_FLAG_EN
        chk("byzero", {63'd0, div_byzero}, {63'd0, mon_e.bz});
`endif
        $display("txn res=%h lat=%0d", div_result, cyc - mon_e.start_cyc);
      end
    end
    ready_prev <= div_ready;
  end

  // Issue one division, hold start for 'hold' extra cycles in END, then drop.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input bit bz,
                         input int hold);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    div_signed  = sgn;
    div_opdata1 = a;
    div_opdata2 = b;
    div_start   = 1'b1;
    e.res       = {r, q};
    e.lat       = bz ? 1 : 32;
    e.bz        = bz;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      // Operands must be ignored once the division has started.
      if (n == 3) begin
        div_opdata1 = ~a;
        div_opdata2 = b + 32'd5;
      end
      if (div_ready) seen = 1;
      else chk("stallreq_wait", {63'd0, stallreq}, 64'd1);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=not_ready expected=ready");
    end
    chk("stallreq_ready", {63'd0, stallreq}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("end_ready_held", {63'd0, div_ready}, 64'd1);
      chk("end_result_held", div_result, {r, q});
    end
    div_start = 1'b0;
    @(negedge clk);
    chk("idle_ready", {63'd0, div_ready}, 64'd0);
    chk("idle_result", div_result, 64'd0);
  endtask

  initial begin
    bit late_ready;
    rst         = 1'b1;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    div_annul   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {63'd0, div_ready}, 64'd0);
    chk("reset_result", div_result, 64'd0);
    chk("reset_stallreq", {63'd0, stallreq}, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
    chk("reset_byzero", {63'd0, div_byzero}, 64'd0);
`endif
    rst = 1'b0;

    //        sgn   dividend       divisor        quotient       remainder    bz hold
    run_div(1'b0, 32'd100,      32'd7,         32'd14,        32'd2,        0, 5);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE, 0, 0);
    run_div(1'b1, 32'd100,      32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,        0, 0);
    run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE, 0, 0);
    run_div(1'b0, 32'hFFFFFF9C, 32'd7,         32'h24924916,  32'd2,        0, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF,  32'h80000000,  32'd0,        0, 0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1,         32'hFFFFFFFF,  32'd0,        0, 0);
    run_div(1'b0, 32'd7,        32'd100,       32'd0,         32'd7,        0, 0);
    run_div(1'b0, 32'd5,        32'd0,         32'd0,         32'd0,        1, 2);
    run_div(1'b1, 32'hFFFFFFF0, 32'd0,         32'd0,         32'd0,        1, 0);

    // Annul during iteration 10 with start still high: annul wins.
    @(negedge clk);
    div_signed  = 1'b0;
    div_opdata1 = 32'd1000;
    div_opdata2 = 32'd7;
    div_start   = 1'b1;
    repeat (10) @(negedge clk);
    div_annul = 1'b1;
    @(negedge clk);
    chk("annul_ready", {63'd0, div_ready}, 64'd0);
    chk("annul_result", div_result, 64'd0);
    div_annul = 1'b0;
    div_start = 1'b0;
    late_ready = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_ready) late_ready = 1;
    end
    chk("annul_no_ready", {63'd0, late_ready}, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    div_signed  = 1'b0;
    div_opdata1 = 32'd100;
    div_opdata2 = 32'd7;
    div_start   = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_ready", {63'd0, div_ready}, 64'd0);
    chk("midreset_result", div_result, 64'd0);
    chk("midreset_stallreq", {63'd0, stallreq}, 64'd1);
    @(negedge clk);
    div_start = 1'b0;
    rst       = 1'b0;
    run_div(1'b0, 32'd50, 32'd7, 32'd7, 32'd1, 0, 0);

    // Hold start in END for a long result on a signed pair.
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 5);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_results actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
